alu_64bit: RTL and testbench

- 64-bit integer ALU for the Y86-64 execute stage.
- Computes add, sub, and, xor on two signed 64-bit operands.
- Registers the result with overflow, zero and sign flags.
- Flags feed the condition-code logic; single-cycle registered latency.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_addsub.sv | 37 +++
 rtl/alu_64bit.sv | 70 +++++++
 tb/tb_alu_64bit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Y86-64 execute-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 64;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// Ripple-carry adder/subtractor: sum = a + (b ^ {sub}) + sub, with signed overflow.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;
    logic             carry;
    logic             carry_msb;

    assign bx = b ^ {WIDTH{sub}};

    // Carry is kept as a loop-local running value so the chain is one combinational cone.
    always_comb begin
        sum       = '0;
        carry     = sub;
        carry_msb = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                carry_msb = carry;
            end
            sum[i] = a[i] ^ bx[i] ^ carry;
            carry  = (a[i] & bx[i]) | (carry & (a[i] ^ bx[i]));
        end
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf = carry_msb ^ carry;

endmodule

// File: rtl/alu_64bit.sv
// Y86-64 execute-stage ALU: add/sub/and/xor with registered result and OF/ZF/SF flags.
module alu_64bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] ans,
    output logic             of,
    output logic             zf,
    output logic             sf,
    output logic             out_valid
);

    alu_op_t          op_sel;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;
    logic [WIDTH-1:0] res;
    logic             res_of;

    assign op_sel = alu_op_t'(op);

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a  (a),
        .b  (b),
        .sub(op_sel == ALU_SUB),
        .sum(sum),
        .ovf(sum_ovf)
    );

    always_comb begin
        res    = '0;
        res_of = 1'b0;
        unique case (op_sel)
            ALU_ADD, ALU_SUB: begin
                res    = sum;
                res_of = sum_ovf;
            end
            ALU_AND: res = a & b;
            ALU_XOR: res = a ^ b;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ans       <= '0;
            of        <= 1'b0;
            zf        <= 1'b1;
            sf        <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            ans       <= res;
            of        <= res_of;
            zf        <= (res == '0);
            sf        <= res[WIDTH-1];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed boundary cases plus random ops against an arithmetic model.
module tb_alu_64bit;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MAXN = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] ans;
    logic         of;
    logic         zf;
    logic         sf;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: what the outputs should show after the most recent edge.
    logic [W-1:0] m_ans = '0;
    logic         m_of = 1'b0;
    logic         m_zf = 1'b1;
    logic         m_sf = 1'b0;
    logic         m_valid = 1'b0;

    alu_64bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .op       (op),
        .ans      (ans),
        .of       (of),
        .zf       (zf),
        .sf       (sf),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact signed arithmetic in a wider type; overflow means the true result does not fit.
    task automatic model_edge();
        logic signed [W+1:0] wa, wb, wr;
        logic signed [W-1:0] t;
        if (reset) begin
            m_ans = '0; m_of = 1'b0; m_zf = 1'b1; m_sf = 1'b0; m_valid = 1'b0;
        end else if (in_valid) begin
            wa = $signed(a);
            wb = $signed(b);
            case (op)
                2'b00: begin wr = wa + wb; t = wr[W-1:0]; m_ans = wr[W-1:0]; m_of = (wr != t); end
                2'b01: begin wr = wa - wb; t = wr[W-1:0]; m_ans = wr[W-1:0]; m_of = (wr != t); end
                2'b10: begin m_ans = a & b; m_of = 1'b0; end
                default: begin m_ans = a ^ b; m_of = 1'b0; end
            endcase
            m_zf = (m_ans == 0);
            m_sf = m_ans[W-1];
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".ans"}, ans, m_ans);
        check({tag, ".of"}, {63'b0, of}, {63'b0, m_of});
        check({tag, ".zf"}, {63'b0, zf}, {63'b0, m_zf});
        check({tag, ".sf"}, {63'b0, sf}, {63'b0, m_sf});
        check({tag, ".valid"}, {63'b0, out_valid}, {63'b0, m_valid});
    endtask

    logic [W-1:0] da [8];
    logic [W-1:0] db [8];
    logic [1:0]   dop [8];
    logic [W-1:0] dans [8];
    logic         dof [8];

    initial begin
        da[0] = MAXP;         db[0] = 64'd1;         dop[0] = 2'b00; dans[0] = MAXN;         dof[0] = 1'b1;
        da[1] = MAXN;         db[1] = 64'd1;         dop[1] = 2'b01; dans[1] = MAXP;         dof[1] = 1'b1;
        da[2] = 64'd123;      db[2] = 64'd1;         dop[2] = 2'b10; dans[2] = 64'd1;        dof[2] = 1'b0;
        da[3] = -64'sd4;      db[3] = -64'sd15;      dop[3] = 2'b11; dans[3] = 64'd13;       dof[3] = 1'b0;
        da[4] = 64'd15;       db[4] = -64'sd3;       dop[4] = 2'b00; dans[4] = 64'd12;       dof[4] = 1'b0;
        da[5] = 64'd9;        db[5] = 64'd9;         dop[5] = 2'b01; dans[5] = 64'd0;        dof[5] = 1'b0;
        da[6] = 64'd0;        db[6] = MAXN;          dop[6] = 2'b01; dans[6] = MAXN;         dof[6] = 1'b1;
        da[7] = MAXP;         db[7] = '1;            dop[7] = 2'b00; dans[7] = MAXP - 64'd1; dof[7] = 1'b0;

        // Reset wins over a valid operation presented at the same time.
        reset = 1'b1; in_valid = 1'b1; a = 64'd5; b = 64'd7; op = 2'b00;
        step("rst0");
        step("rst1");
        reset = 1'b0; in_valid = 1'b0;
        step("hold0");
        step("hold1");

        // Directed cases back-to-back; each result lands exactly one edge later.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = da[i]; b = db[i]; op = dop[i];
            step($sformatf("dir%0d", i));
            check($sformatf("dir%0d.const_ans", i), ans, dans[i]);
            check($sformatf("dir%0d.const_of", i), {63'b0, of}, {63'b0, dof[i]});
        end

        // Idle after a result: value holds, valid drops.
        in_valid = 1'b0; a = '1; b = '1; op = 2'b01;
        step("idle");
        check("idle.const_ans", ans, MAXP - 64'd1);

        // Mid-stream reset with a valid op present.
        in_valid = 1'b1; a = 64'd3; b = 64'd4; op = 2'b00;
        step("pre_rst");
        reset = 1'b1;
        step("mid_rst");
        check("mid_rst.const_zf", {63'b0, zf}, 64'd1);
        reset = 1'b0;

        // Random traffic with bubbles, a - a cases, boundary operands and rare resets.
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 7);
            reset    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            op       = 2'($urandom_range(0, 3));
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            case (sel)
                0: b = a;
                1: a = MAXP;
                2: a = MAXN;
                3: b = MAXN;
                4: b = 64'd1;
                default: ;
            endcase
            step($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
